// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared defaults and state encoding for the dot-product
//               operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

    localparam int c_VEC_LEN = 16;
    localparam int c_TIMEOUT = 8191;
    localparam int c_CNT_W   = 13;

    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUTPUT = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/dot_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : dot_operand_loader
// Description : Streams two byte vectors into operand registers, kicks the
//               dot-product stage and returns its result (or a timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module dot_operand_loader
    import npu_pkg::*;
#(
    parameter int VEC_LEN = c_VEC_LEN,
    parameter int TIMEOUT = c_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic [VEC_LEN-1:0][7:0] dot_a,
    output logic [VEC_LEN-1:0][7:0] dot_b,
    output logic                    dot_start,
    input  logic [15:0]             dot_c,
    input  logic                    dot_done,
    output logic                    out_valid,
    output logic [15:0]             out_data,
    output logic                    out_err,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int c_IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(VEC_LEN - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};
    // A TIMEOUT beyond the counter range saturates to the counter maximum.
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT =
        (TIMEOUT > ((1 << c_CNT_W) - 1)) ? c_CNT_MAX : c_CNT_W'(TIMEOUT);

    loader_state_t             r_state;
    loader_state_t             w_state_next;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_done_q;
    logic [VEC_LEN-1:0][7:0]   r_dot_a;
    logic [VEC_LEN-1:0][7:0]   r_dot_b;
    logic [15:0]               r_out_data;
    logic                      r_out_err;

    logic w_take;
    logic w_edge;
    logic w_timeout;

    assign w_take    = in_valid & in_ready;
    assign w_edge    = dot_done & ~r_done_q;
    assign w_timeout = (r_cnt == c_TIMEOUT_CNT);

    assign dot_a    = r_dot_a;
    assign dot_b    = r_dot_b;
    assign out_data = r_out_data;
    assign out_err  = r_out_err;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        dot_start    = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_LOAD_A: begin
                in_ready = 1'b1;
                busy     = (r_idx != '0);
                if (w_take && (r_idx == c_IDX_LAST)) w_state_next = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                if (w_take && (r_idx == c_IDX_LAST)) w_state_next = ST_START;
            end
            ST_START: begin
                dot_start    = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_edge || w_timeout) w_state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_LOAD_A;
            end
            default: w_state_next = ST_LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_LOAD_A;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_done_q   <= 1'b0;
            r_dot_a    <= '0;
            r_dot_b    <= '0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_done_q <= dot_done;
            case (r_state)
                ST_LOAD_A: begin
                    if (w_take) begin
                        r_dot_a[r_idx] <= in_data;
                        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
                    end
                end
                ST_LOAD_B: begin
                    if (w_take) begin
                        r_dot_b[r_idx] <= in_data;
                        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
                    end
                end
                ST_START: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    // A done edge takes priority over a simultaneous timeout.
                    if (w_edge) begin
                        r_out_data <= dot_c;
                        r_out_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_out_data <= dot_c;
                        r_out_err  <= 1'b1;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_operand_loader
// Description : Directed self-checking bench for dot_operand_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_operand_loader;

    localparam int VL = 16;
    localparam int TO = 40;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic [VL-1:0][7:0] dot_a;
    logic [VL-1:0][7:0] dot_b;
    logic               dot_start;
    logic [15:0]        dot_c;
    logic               dot_done;
    logic               out_valid;
    logic [15:0]        out_data;
    logic               out_err;
    logic               out_ready;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]         va [VL];
    logic [7:0]         vb [VL];
    logic [VL-1:0][7:0] exp_a;
    logic [VL-1:0][7:0] exp_b;

    int          model_mode  = 0;
    int          model_delay = 5;
    int          model_cnt   = 0;
    int          start_pulses = 0;
    logic [15:0] acc;

    dot_operand_loader #(.VEC_LEN(VL), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .dot_a     (dot_a),
        .dot_b     (dot_b),
        .dot_start (dot_start),
        .dot_c     (dot_c),
        .dot_done  (dot_done),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Dot-product stage model: mode 0 drops done on start and raises it
    // model_delay cycles later; mode 1 leaves done untouched (sticky).
    initial begin
        dot_done = 1'b0;
        dot_c    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dot_start) begin
                start_pulses++;
                acc = '0;
                for (int i = 0; i < VL; i++) acc = acc + 16'(dot_a[i]) * 16'(dot_b[i]);
                dot_c = acc;
                if (model_mode == 0) begin
                    dot_done  = 1'b0;
                    model_cnt = model_delay;
                end
            end else if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0) dot_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_expected();
        for (int i = 0; i < VL; i++) begin
            exp_a[i] = va[i];
            exp_b[i] = vb[i];
        end
    endtask

    task automatic load_vectors(input int gap, input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            int guard;
            if (gap != 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = (k < VL) ? va[k] : vb[k - VL];
            guard = 0;
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles, output bit ok);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            tick();
            cycles++;
        end
        ok = out_valid;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 16'd0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL reset_out_err: got %b want 0", out_err); else n_pass++;
        n_checks++; if (dot_start !== 1'b0) $display("FAIL reset_dot_start: got %b want 0", dot_start); else n_pass++;
        n_checks++; if (dot_a !== '0) $display("FAIL reset_dot_a: got %h want 0", dot_a); else n_pass++;
        n_checks++; if (dot_b !== '0) $display("FAIL reset_dot_b: got %h want 0", dot_b); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        int cyc; bit ok;
        for (int i = 0; i < VL; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd2; end
        build_expected();
        model_mode = 0; model_delay = 5; start_pulses = 0;
        load_vectors(0, 2 * VL);
        n_checks++; if (dot_start !== 1'b1) $display("FAIL basic_start_latency: got %b want 1", dot_start); else n_pass++;
        n_checks++; if (dot_a !== exp_a) $display("FAIL basic_dot_a: got %h want %h", dot_a, exp_a); else n_pass++;
        n_checks++; if (dot_b !== exp_b) $display("FAIL basic_dot_b: got %h want %h", dot_b, exp_b); else n_pass++;
        wait_out(cyc, ok);
        n_checks++; if (!ok || cyc != 6) $display("FAIL basic_latency: got %0d cycles (valid %b) want 6", cyc, ok); else n_pass++;
        n_checks++; if (out_data !== 16'd272) $display("FAIL basic_data: got %0d want 272", out_data); else n_pass++;
        n_checks++; if (out_err !== 1'b0) $display("FAIL basic_err: got %b want 0", out_err); else n_pass++;
        n_checks++; if (start_pulses != 1) $display("FAIL basic_start_pulses: got %0d want 1", start_pulses); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_output: got %b want 1", busy); else n_pass++;
        handshake();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL basic_idle: got ready %b busy %b want 1 0", in_ready, busy); else n_pass++;
    endtask

    task automatic test_gaps();
        int cyc; bit ok;
        model_mode = 0; model_delay = 5;
        load_vectors(1, 2 * VL);
        n_checks++; if (dot_a !== exp_a || dot_b !== exp_b) $display("FAIL gaps_operands: got %h %h want %h %h", dot_a, dot_b, exp_a, exp_b); else n_pass++;
        wait_out(cyc, ok);
        n_checks++; if (!ok || out_data !== 16'd272 || out_err !== 1'b0) $display("FAIL gaps_result: got %0d err %b valid %b want 272 err 0", out_data, out_err, ok); else n_pass++;
        handshake();
    endtask

    task automatic test_sticky_and_backpressure();
        int cyc; bit ok;
        model_mode = 1; dot_done = 1'b1;
        load_vectors(0, 2 * VL);
        wait_out(cyc, ok);
        n_checks++; if (!ok || cyc != TO + 2) $display("FAIL sticky_latency: got %0d cycles (valid %b) want %0d", cyc, ok, TO + 2); else n_pass++;
        n_checks++; if (out_err !== 1'b1) $display("FAIL sticky_err: got %b want 1", out_err); else n_pass++;
        n_checks++; if (out_data !== 16'd272) $display("FAIL sticky_data: got %0d want 272", out_data); else n_pass++;
        in_valid = 1'b1; in_data = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'd272 || out_err !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL hold_cycle%0d: got valid %b data %0d err %b ready %b want 1 272 1 0", i, out_valid, out_data, out_err, in_ready);
            else n_pass++;
        end
        in_valid = 1'b0;
        handshake();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL hold_valid_drop: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (dot_a !== exp_a || dot_b !== exp_b) $display("FAIL hold_operands: got %h %h want %h %h", dot_a, dot_b, exp_a, exp_b); else n_pass++;
    endtask

    task automatic test_reset_midload();
        int cyc; bit ok;
        for (int i = 0; i < VL; i++) begin va[i] = 8'd3; vb[i] = 8'(i + 1); end
        build_expected();
        model_mode = 0; model_delay = 3;
        load_vectors(0, 20);
        n_checks++; if (busy !== 1'b1) $display("FAIL midload_busy: got %b want 1", busy); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (dot_a !== '0 || dot_b !== '0) $display("FAIL midload_clear: got %h %h want 0 0", dot_a, dot_b); else n_pass++;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL midload_idle: got busy %b ready %b want 0 1", busy, in_ready); else n_pass++;
        load_vectors(0, 2 * VL);
        n_checks++; if (dot_a !== exp_a || dot_b !== exp_b) $display("FAIL midload_operands: got %h %h want %h %h", dot_a, dot_b, exp_a, exp_b); else n_pass++;
        wait_out(cyc, ok);
        n_checks++; if (!ok || cyc != 4) $display("FAIL midload_latency: got %0d cycles (valid %b) want 4", cyc, ok); else n_pass++;
        n_checks++; if (out_data !== 16'd408 || out_err !== 1'b0) $display("FAIL midload_result: got %0d err %b want 408 err 0", out_data, out_err); else n_pass++;
        handshake();
    endtask

    task automatic test_timeout_boundary();
        int cyc; bit ok;
        for (int i = 0; i < VL; i++) begin va[i] = 8'(i + 1); vb[i] = 8'd2; end
        model_mode = 0; model_delay = TO + 1;
        load_vectors(0, 2 * VL);
        wait_out(cyc, ok);
        n_checks++; if (!ok || cyc != TO + 2) $display("FAIL coincide_latency: got %0d cycles (valid %b) want %0d", cyc, ok, TO + 2); else n_pass++;
        n_checks++; if (out_err !== 1'b0 || out_data !== 16'd272) $display("FAIL coincide_result: got %0d err %b want 272 err 0", out_data, out_err); else n_pass++;
        handshake();
        model_delay = TO + 2;
        load_vectors(0, 2 * VL);
        wait_out(cyc, ok);
        n_checks++; if (!ok || cyc != TO + 2) $display("FAIL late_latency: got %0d cycles (valid %b) want %0d", cyc, ok, TO + 2); else n_pass++;
        n_checks++; if (out_err !== 1'b1) $display("FAIL late_err: got %b want 1", out_err); else n_pass++;
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_sticky_and_backpressure();
        test_reset_midload();
        test_timeout_boundary();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dot_operand_loader.md
DOT_OPERAND_LOADER -- requirements
Module: dot_operand_loader

Interface
REQ-001 SHALL have parameter VEC_LEN, default 16; number of 8-bit elements per operand vector.
REQ-002 SHALL have parameter TIMEOUT, default 8191; max cycles waited for dot_done before forced capture.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_data  input  8  upstream operand byte; first VEC_LEN bytes are a[0..], next VEC_LEN are b[0..].
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 dot_a  output  8 x VEC_LEN  operand array a to dot-product stage.
REQ-009 dot_b  output  8 x VEC_LEN  operand array b to dot-product stage.
REQ-010 dot_start  output  1  one-cycle start pulse to dot-product stage.
REQ-011 dot_c  input  16  dot-product result.
REQ-012 dot_done  input  1  dot-product completion flag; may be sticky high.
REQ-013 out_valid  output  1  result word available downstream.
REQ-014 out_data  output  16  captured result.
REQ-015 out_err  output  1  result was captured by timeout, not by dot_done edge.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 busy  output  1  high in every state except LOAD_A with index 0.

Function
REQ-018 SHALL implement FSM states LOAD_A, LOAD_B, START, WAIT, OUTPUT.
REQ-019 in_ready SHALL be 1 exactly in LOAD_A and LOAD_B; a byte is taken when in_valid and in_ready are both 1.
REQ-020 LOAD_A: accepted byte written to dot_a[idx], idx+1; at idx==VEC_LEN-1, idx->0 and go to LOAD_B.
REQ-021 LOAD_B: same into dot_b; on last byte go to START.
REQ-022 START: dot_start=1 for exactly one cycle; clear timeout counter; go to WAIT.
REQ-023 WAIT: track dot_done_q (registered dot_done); a rising edge (dot_done & ~dot_done_q), counted from the cycle after START, captures dot_c into out_data with out_err=0 and enters OUTPUT.
REQ-024 WAIT: if timeout counter reaches TIMEOUT with no rising edge, capture dot_c with out_err=1 and enter OUTPUT.
REQ-025 Rising edge and timeout in the same cycle: the edge wins, out_err=0.
REQ-026 OUTPUT: out_valid=1 and out_data/out_err held stable until out_ready=1; on handshake, out_valid->0 next cycle and go to LOAD_A.
REQ-027 dot_a/dot_b SHALL be held unchanged from START until the next LOAD_A write.
REQ-028 in_valid outside LOAD_A/LOAD_B SHALL be ignored; no byte is consumed.
REQ-029 Timeout counter SHALL be 13 bits, saturating; TIMEOUT >= 4200 covers worst-case 16x255-cycle compute.
REQ-030 Latency: last b byte accepted at cycle t -> dot_start at t+1; out_valid at the cycle after the capture condition.

Reset
REQ-031 On rst=1: state=LOAD_A, idx=0, counter=0, dot_done_q=0, dot_a/dot_b all 0, dot_start=0, out_valid=0, out_data=0, out_err=0; in_ready=1 after rst deasserts.
REQ-032 rst asserted mid-load, mid-WAIT or mid-OUTPUT SHALL abandon the transaction; a pending result is discarded.

Structure
REQ-033 Package npu_pkg SHALL hold VEC_LEN, TIMEOUT defaults and the loader state enum type.
REQ-034 Single module, no sub-modules; idx width $clog2(VEC_LEN).

Verification
REQ-035 Bytes a=1..16, b=all 2, with a model dot stage whose done rises once -> one dot_start pulse, out_data=272, out_err=0.
REQ-036 in_valid toggled every other cycle during load -> same 32 bytes captured, result identical to gap-free load.
REQ-037 dot_done held sticky high from a prior run -> no edge; out_valid after TIMEOUT+1 cycles in WAIT with out_err=1.
REQ-038 out_ready low for 10 cycles in OUTPUT -> out_valid/out_data stable; extra in_valid bytes not consumed (in_ready=0).
REQ-039 rst pulsed after 20 bytes loaded -> dot_a/dot_b cleared, idx=0; next 32 bytes yield the correct result.
REQ-040 dot_done edge coincident with the timeout cycle -> out_err=0.
